// File: rtl/pulse_monitor.sv
// Purpose : per-channel pulse statistics (edge count, high time, longest pulse,
//           last-rise timestamp) with an atomic shadow snapshot behind a local register port.
// Latency : pulse_in to counter update is 2 clk edges; register reads return 1 cycle after local_ren.
// Backpressure: none; every read strobe is answered on the next cycle and back-to-back reads are accepted.
//
// Ports:
//   clk, rst                    sole clock, synchronous active-high reset
//   pulse_in[NUM_CHANNELS]      monitored lines, synchronous to clk
//   local_waddr/wen/wdata       word-addressed register write port
//   local_raddr/ren             word-addressed register read request
//   local_rdata/rdatavalid      read response, valid one cycle after local_ren
module pulse_monitor #(
    parameter int NUM_CHANNELS       = 2,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CHANNELS-1:0]         pulse_in,
    input  logic [C_S_AXI_ADDR_WIDTH-3:0]   local_waddr,
    input  logic                            local_wen,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   local_wdata,
    input  logic [C_S_AXI_ADDR_WIDTH-3:0]   local_raddr,
    input  logic                            local_ren,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   local_rdata,
    output logic                            local_rdatavalid
);

    localparam int AW = C_S_AXI_ADDR_WIDTH - 2;

    // Word addresses (byte address >> 2).
    localparam logic [AW-1:0] A_CTRL    = AW'(0);
    localparam logic [AW-1:0] A_SNAP    = AW'(1);
    localparam logic [AW-1:0] A_CLEAR   = AW'(2);
    localparam logic [AW-1:0] A_TS      = AW'(3);
    localparam logic [AW-1:0] A_CH_BASE = AW'(64);   // byte 0x100
    localparam logic [AW-1:0] A_CH_END  = AW'(128);  // 8 channels x 8 words

    typedef enum logic {
        IDLE = 1'b0,
        HIGH = 1'b1
    } ch_state_t;

    // Input stage
    logic [NUM_CHANNELS-1:0] p_q;
    logic [NUM_CHANNELS-1:0] p_qq;

    // Control and timestamp
    logic        ctrl_en;
    logic        ctrl_cos;
    logic [31:0] ts_q;

    // Live per-channel state
    ch_state_t                     st_q   [NUM_CHANNELS];
    ch_state_t                     st_nxt [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0][31:0] edge_cnt;
    logic [NUM_CHANNELS-1:0][31:0] high_cyc;
    logic [NUM_CHANNELS-1:0][31:0] cur_w;
    logic [NUM_CHANNELS-1:0][31:0] max_w;
    logic [NUM_CHANNELS-1:0][31:0] last_ts;
    logic [NUM_CHANNELS-1:0][31:0] edge_nxt;
    logic [NUM_CHANNELS-1:0][31:0] high_nxt;
    logic [NUM_CHANNELS-1:0][31:0] cur_nxt;
    logic [NUM_CHANNELS-1:0][31:0] max_nxt;
    logic [NUM_CHANNELS-1:0][31:0] last_nxt;

    // Shadow copies seen by software
    logic [NUM_CHANNELS-1:0][31:0] sh_edge;
    logic [NUM_CHANNELS-1:0][31:0] sh_high;
    logic [NUM_CHANNELS-1:0][31:0] sh_max;
    logic [NUM_CHANNELS-1:0][31:0] sh_last;

    logic wr_ctrl;
    logic wr_snap;
    logic wr_clear;
    logic live_clr;

    logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux;
    logic [2:0]                    rd_ch;
    logic [2:0]                    rd_fld;

    logic unused_wdata;
    assign unused_wdata = ^local_wdata[C_S_AXI_DATA_WIDTH-1:2];

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign wr_ctrl  = local_wen && (local_waddr == A_CTRL);
    assign wr_snap  = local_wen && (local_waddr == A_SNAP);
    assign wr_clear = local_wen && (local_waddr == A_CLEAR);
    // Clearing restarts the period; this cycle's event is applied on top of zero.
    assign live_clr = wr_clear || (wr_snap && ctrl_cos);

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q      <= '0;
            p_qq     <= '0;
            ts_q     <= '0;
            ctrl_en  <= 1'b0;
            ctrl_cos <= 1'b0;
        end else begin
            p_q  <= pulse_in;
            p_qq <= p_q;
            ts_q <= ts_q + 32'd1;
            if (wr_ctrl) begin
                ctrl_en  <= local_wdata[0];
                ctrl_cos <= local_wdata[1];
            end
        end
    end

    // Next-state and counter updates. The channel counts as HIGH from the
    // detection cycle, so a line high for N cycles at p_q adds exactly N.
    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            st_nxt[i]   = st_q[i];
            edge_nxt[i] = live_clr ? 32'd0 : edge_cnt[i];
            high_nxt[i] = live_clr ? 32'd0 : high_cyc[i];
            cur_nxt[i]  = live_clr ? 32'd0 : cur_w[i];
            max_nxt[i]  = live_clr ? 32'd0 : max_w[i];
            last_nxt[i] = live_clr ? 32'd0 : last_ts[i];
            unique case (st_q[i])
                IDLE: begin
                    if (ctrl_en && p_q[i] && !p_qq[i]) begin
                        st_nxt[i]   = HIGH;
                        edge_nxt[i] = sat_inc(edge_nxt[i]);
                        high_nxt[i] = sat_inc(high_nxt[i]);
                        cur_nxt[i]  = 32'd1;
                        last_nxt[i] = ts_q;
                    end
                end
                HIGH: begin
                    if (!ctrl_en || !p_q[i]) begin
                        st_nxt[i] = IDLE;
                        // A pulse ending in a clearing cycle belongs to the old period.
                        if (!live_clr && (cur_w[i] > max_w[i])) begin
                            max_nxt[i] = cur_w[i];
                        end
                    end else begin
                        high_nxt[i] = sat_inc(high_nxt[i]);
                        cur_nxt[i]  = sat_inc(cur_nxt[i]);
                    end
                end
                default: st_nxt[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (rst) begin
                st_q[i]     <= IDLE;
                edge_cnt[i] <= '0;
                high_cyc[i] <= '0;
                cur_w[i]    <= '0;
                max_w[i]    <= '0;
                last_ts[i]  <= '0;
                sh_edge[i]  <= '0;
                sh_high[i]  <= '0;
                sh_max[i]   <= '0;
                sh_last[i]  <= '0;
            end else begin
                st_q[i]     <= st_nxt[i];
                edge_cnt[i] <= edge_nxt[i];
                high_cyc[i] <= high_nxt[i];
                cur_w[i]    <= cur_nxt[i];
                max_w[i]    <= max_nxt[i];
                last_ts[i]  <= last_nxt[i];
                // Shadows take the pre-update live values.
                if (wr_snap) begin
                    sh_edge[i] <= edge_cnt[i];
                    sh_high[i] <= high_cyc[i];
                    sh_max[i]  <= max_w[i];
                    sh_last[i] <= last_ts[i];
                end
            end
        end
    end

    assign rd_ch  = local_raddr[5:3];
    assign rd_fld = local_raddr[2:0];

    always_comb begin
        rd_mux = '0;
        if (local_raddr == A_CTRL) begin
            rd_mux[1:0] = {ctrl_cos, ctrl_en};
        end else if (local_raddr == A_TS) begin
            rd_mux = ts_q;
        end else if ((local_raddr >= A_CH_BASE) && (local_raddr < A_CH_END)) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (rd_ch == 3'(c)) begin
                    case (rd_fld)
                        3'd0:    rd_mux = sh_edge[c];
                        3'd1:    rd_mux = sh_high[c];
                        3'd2:    rd_mux = sh_max[c];
                        3'd3:    rd_mux = sh_last[c];
                        default: rd_mux = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            local_rdata      <= '0;
            local_rdatavalid <= 1'b0;
        end else begin
            local_rdatavalid <= local_ren;
            local_rdata      <= local_ren ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_pulse_monitor.sv
// Purpose : self-checking bench for pulse_monitor; read expectations are queued at request time.
// Latency : responses are matched against the queue when local_rdatavalid is seen.
// Backpressure: none; the bench issues reads freely, including back-to-back.
module tb_pulse_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pulse_in = '0;
    logic [9:0]  local_waddr = '0;
    logic        local_wen = 1'b0;
    logic [31:0] local_wdata = '0;
    logic [9:0]  local_raddr = '0;
    logic        local_ren = 1'b0;
    logic [31:0] local_rdata;
    logic        local_rdatavalid;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] tb_ts = '0;
    logic        ren_d = 1'b0;
    logic [31:0] exp_ts;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    pulse_monitor #(
        .NUM_CHANNELS       (2),
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (12)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pulse_in         (pulse_in),
        .local_waddr      (local_waddr),
        .local_wen        (local_wen),
        .local_wdata      (local_wdata),
        .local_raddr      (local_raddr),
        .local_ren        (local_ren),
        .local_rdata      (local_rdata),
        .local_rdatavalid (local_rdatavalid)
    );

    always #5 clk = ~clk;

    // Reference free-running timestamp.
    always @(posedge clk) begin
        if (rst) tb_ts <= '0;
        else     tb_ts <= tb_ts + 32'd1;
        ren_d <= local_ren;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        local_waddr = a;
        local_wdata = d;
        local_wen   = 1'b1;
        tick();
        local_wen   = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a, input logic [31:0] e, input string tag);
        local_raddr = a;
        local_ren   = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        tick();
        local_ren   = 1'b0;
    endtask

    // Response monitor: timing of valid and scoreboard pop.
    always @(negedge clk) begin
        if (!rst) begin
            if (ren_d || local_rdatavalid)
                check("rvalid_timing", {31'b0, local_rdatavalid}, {31'b0, ren_d});
            if (local_rdatavalid) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", 32'(exp_q.size()), 32'd1);
                end else begin
                    check(tag_q.pop_front(), local_rdata, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int widths[3] = '{5, 12, 7};

        repeat (3) tick();
        rst = 1'b0;
        check("rst_rvalid", {31'b0, local_rdatavalid}, 32'd0);
        check("rst_rdata", local_rdata, 32'd0);

        // Reset state
        rd(10'h000, 32'd0, "ctrl_rst");
        rd(10'h003, tb_ts, "ts_rst");
        for (int k = 0; k < 4; k++) rd(10'h040 + 10'(k), 32'd0, "ch0_rst");

        // Three pulses on ch0
        wr(10'h000, 32'd1);
        for (int p = 0; p < 3; p++) begin
            pulse_in[0] = 1'b1;
            exp_ts = tb_ts + 32'd1;
            repeat (widths[p]) tick();
            pulse_in[0] = 1'b0;
            repeat (4) tick();
        end
        wr(10'h001, 32'd0);
        rd(10'h040, 32'd3,  "ch0_edge");
        rd(10'h041, 32'd24, "ch0_high");
        rd(10'h042, 32'd12, "ch0_max");
        rd(10'h043, exp_ts, "ch0_last_ts");
        rd(10'h048, 32'd0,  "ch1_idle_edge");

        // Snapshot mid-pulse: max excludes the unfinished pulse
        pulse_in[0] = 1'b1;
        repeat (20) tick();
        wr(10'h001, 32'd0);
        rd(10'h042, 32'd12, "ch0_max_midpulse");
        rd(10'h040, 32'd4,  "ch0_edge_midpulse");
        pulse_in[0] = 1'b0;
        repeat (3) tick();

        // Line already high when enabled
        wr(10'h000, 32'd0);
        wr(10'h002, 32'd0);
        pulse_in[1] = 1'b1;
        repeat (3) tick();
        wr(10'h000, 32'd1);
        repeat (5) tick();
        wr(10'h001, 32'd0);
        rd(10'h048, 32'd0, "ch1_prehigh_edge");
        rd(10'h040, 32'd0, "ch0_after_clear");
        pulse_in[1] = 1'b0;
        repeat (3) tick();
        pulse_in[1] = 1'b1;
        repeat (4) tick();
        pulse_in[1] = 1'b0;
        repeat (3) tick();
        wr(10'h001, 32'd0);
        rd(10'h048, 32'd1, "ch1_fresh_edge");
        rd(10'h049, 32'd4, "ch1_fresh_high");

        // clear_on_snap with a rise in the snapshot cycle
        wr(10'h000, 32'd3);
        pulse_in[1] = 1'b1;
        tick();
        exp_ts = tb_ts;
        wr(10'h001, 32'd0);
        repeat (3) tick();
        pulse_in[1] = 1'b0;
        repeat (3) tick();
        rd(10'h048, 32'd1, "cos_old_edge");
        rd(10'h049, 32'd4, "cos_old_high");
        wr(10'h000, 32'd1);
        wr(10'h001, 32'd0);
        rd(10'h048, 32'd1, "cos_new_edge");
        rd(10'h049, 32'd5, "cos_new_high");
        rd(10'h04A, 32'd5, "cos_new_max");
        rd(10'h04B, exp_ts, "cos_new_last_ts");

        // high_cyc saturation on ch1
        pulse_in[1] = 1'b1;
        repeat (3) tick();
        force dut.high_cyc = 64'hFFFF_FFF0_0000_0000;
        repeat (2) tick();
        release dut.high_cyc;
        repeat (30) tick();
        wr(10'h001, 32'd0);
        rd(10'h049, 32'hFFFF_FFFF, "ch1_high_sat");
        repeat (10) tick();
        wr(10'h001, 32'd0);
        rd(10'h049, 32'hFFFF_FFFF, "ch1_high_nowrap");
        rd(10'h048, 32'd2, "ch1_edge_sat_run");
        pulse_in[1] = 1'b0;
        repeat (3) tick();

        // Unmapped / write-only / absent channel, RO write
        rd(10'h050, 32'd0, "ch2_absent");
        rd(10'h004, 32'd0, "unmapped_010");
        rd(10'h001, 32'd0, "snap_wo");
        wr(10'h003, 32'hDEAD_BEEF);
        rd(10'h003, tb_ts, "ts_after_wr");
        rd(10'h000, 32'd1, "ctrl_rb");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
